// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode and state encodings plus datapath select codes for the multicycle controller
package cpu_pkg;
  typedef enum logic [3:0] {
    OP_R    = 4'd0,
    OP_LW   = 4'd1,
    OP_SW   = 4'd2,
    OP_ADDI = 4'd3,
    OP_BEQ  = 4'd4,
    OP_BNE  = 4'd5,
    OP_JMP  = 4'd6
  } opcode_e;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP, HALT
  } state_e;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing fetch/decode/execute strobes for a multicycle CPU datapath
module multicycle_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       halted
);
  state_e state_q, state_d;
  // state register; reset wins from any state, including waits and HALT
  always_ff @(posedge clk) state_q <= reset ? FETCH : state_d;
  // next-state and output decode; everything forced low while reset is held
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    pc_src     = PC_ALU;
    instr_done = 1'b0;
    halted     = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = SRCB_ONE;
            state_d   = DECODE;
          end
        end
        DECODE: begin
          alu_src_b = SRCB_IMM;
          case (opcode)
            OP_LW, OP_SW:   state_d = MEM_ADDR;
            OP_R:           state_d = R_EXEC;
            OP_ADDI:        state_d = ADDI_EXEC;
            OP_BEQ, OP_BNE: state_d = BRANCH;
            OP_JMP:         state_d = JUMP;
            default:        state_d = HALT;
          endcase
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = (opcode == OP_SW) ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          state_d = mem_ready ? MEM_WB : MEM_RD;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        MEM_WR: begin
          mem_req    = 1'b1;
          iord       = 1'b1;
          mem_we     = 1'b1;
          instr_done = mem_ready;
          state_d    = mem_ready ? FETCH : MEM_WR;
        end
        R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_RTYPE;
          state_d   = R_WB;
        end
        ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = ADDI_WB;
        end
        R_WB, ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_src     = PC_ALUOUT;
          pc_write   = (opcode == OP_BNE) ? !alu_zero : alu_zero;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        JUMP: begin
          pc_write   = 1'b1;
          pc_src     = PC_JUMP;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        HALT: halted = 1'b1;
        default: state_d = FETCH;
      endcase
    end
  end
endmodule
